// File: rtl/aludec_mc_pkg.sv
// Shared types and constants for the multi-cycle ALU decoder: FSM states,
// ALU control codes and main-decoder aluop classes.
package aludec_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  // M-extension ops occupy 16..23, offset by funct3
  localparam logic [4:0] ALU_MBASE = 5'd16;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

endpackage

// File: rtl/aludec_core.sv
// Combinational ALU decode: maps aluop/funct fields to an ALU control code
// and classifies the request as illegal, multiply or divide.
module aludec_core
  import aludec_mc_pkg::*;
#(
  parameter int ALUCTRL_W = 5
) (
  input  logic                 opb5,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 funct7b0,
  input  logic [1:0]           aluop,
  output logic [ALUCTRL_W-1:0] code,
  output logic                 illegal,
  output logic                 is_mul,
  output logic                 is_div
);

  logic [4:0] base;
  logic       rtype;

  assign rtype = opb5 && (aluop == ALUOP_FUNCT);

  always_comb begin
    base    = ALU_ADD;
    illegal = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    case (aluop)
      ALUOP_ADD: base = ALU_ADD;
      ALUOP_SUB: base = ALU_SUB;
      ALUOP_FUNCT: begin
        if (rtype && funct7b0 && funct7b5) begin
          illegal = 1'b1;
        end else if (rtype && funct7b0) begin
          base   = ALU_MBASE | {2'b00, funct3};
          is_mul = ~funct3[2];
          is_div = funct3[2];
        end else if (rtype && funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
          illegal = 1'b1;
        end else begin
          case (funct3)
            3'b000:  base = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  base = ALU_SLL;
            3'b010:  base = ALU_SLT;
            3'b011:  base = ALU_SLTU;
            3'b100:  base = ALU_XOR;
            3'b101:  base = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  base = ALU_OR;
            default: base = ALU_AND;
          endcase
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  // illegal requests report code 0 because base keeps its default
  assign code = ALUCTRL_W'(base);

endmodule

// File: rtl/aludec_mc.sv
// Multi-cycle ALU decoder: registers the decoded ALU code at accept and
// models multiply/divide occupancy with a down-counter before a result strobe.
module aludec_mc
  import aludec_mc_pkg::*;
#(
  parameter int ALUCTRL_W  = 5,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_flush,
  input  logic                 i_opb5,
  input  logic [2:0]           i_funct3,
  input  logic                 i_funct7b5,
  input  logic                 i_funct7b0,
  input  logic [1:0]           i_aluop,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [ALUCTRL_W-1:0] o_alucrtl,
  output logic                 o_illegal,
  output logic                 o_busy
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  if (ALUCTRL_W < 5) begin : g_bad_width
    $error("aludec_mc: ALUCTRL_W must be at least 5");
  end
  if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_cycles
    $error("aludec_mc: MUL_CYCLES and DIV_CYCLES must be at least 1");
  end

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ALUCTRL_W-1:0] code_q;
  logic                 illegal_q;
  logic [ALUCTRL_W-1:0] dec_code;
  logic                 dec_illegal, dec_mul, dec_div;
  logic                 accept;

  aludec_core #(.ALUCTRL_W(ALUCTRL_W)) u_core (
    .opb5     (i_opb5),
    .funct3   (i_funct3),
    .funct7b5 (i_funct7b5),
    .funct7b0 (i_funct7b0),
    .aluop    (i_aluop),
    .code     (dec_code),
    .illegal  (dec_illegal),
    .is_mul   (dec_mul),
    .is_div   (dec_div)
  );

  // valid/ready: a request transfers on a rising edge when i_valid and
  // o_ready are both high and i_flush is low; o_valid is a one-cycle strobe.
  assign accept = i_valid && (state_q == ST_IDLE) && !i_flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            if (dec_mul) begin
              state_d = ST_MUL;
              cnt_d   = CNT_W'(MUL_CYCLES - 1);
            end else if (dec_div) begin
              state_d = ST_DIV;
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_q == '0) state_d = ST_DONE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      code_q    <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      code_q    <= dec_code;
      illegal_q <= dec_illegal;
    end
  end

  assign o_ready   = (state_q == ST_IDLE);
  assign o_busy    = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign o_valid   = (state_q == ST_DONE) && !i_flush;
  assign o_alucrtl = code_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_aludec_mc.sv
// Bench for aludec_mc: directed corner cases followed by randomized requests
// checked against a rule-level decode and latency model.
module tb_aludec_mc;

  localparam int W    = 5;
  localparam int MULC = 2;
  localparam int DIVC = 32;

  logic         i_clk = 1'b0;
  logic         i_rst, i_valid, i_flush, i_opb5, i_funct7b5, i_funct7b0;
  logic [2:0]   i_funct3;
  logic [1:0]   i_aluop;
  logic         o_ready, o_valid, o_illegal, o_busy;
  logic [W-1:0] o_alucrtl;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  aludec_mc #(.ALUCTRL_W(W), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_flush    (i_flush),
    .i_opb5     (i_opb5),
    .i_funct3   (i_funct3),
    .i_funct7b5 (i_funct7b5),
    .i_funct7b0 (i_funct7b0),
    .i_aluop    (i_aluop),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_alucrtl  (o_alucrtl),
    .o_illegal  (o_illegal),
    .o_busy     (o_busy)
  );

  // clock / reset block
  always #5 i_clk = ~i_clk;

  typedef struct {
    int code;
    bit ill;
    int lat;
  } ref_t;

  // Reference decode: code, illegal flag and accept-to-valid latency.
  function automatic ref_t ref_model(input int aluop, input int opb5, input int f3,
                                     input int f7b5, input int f7b0);
    int   tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    ref_t r;
    r.code = 0;
    r.ill  = 1'b0;
    r.lat  = 1;
    if (aluop == 0) r.code = 0;
    else if (aluop == 1) r.code = 1;
    else if (aluop == 3) r.ill = 1'b1;
    else if (opb5 != 0 && f7b0 != 0 && f7b5 != 0) r.ill = 1'b1;
    else if (opb5 != 0 && f7b0 != 0) begin
      r.code = 16 + f3;
      r.lat  = (f3 < 4) ? MULC + 1 : DIVC + 1;
    end else if (opb5 != 0 && f7b5 != 0 && f3 != 0 && f3 != 5) r.ill = 1'b1;
    else begin
      r.code = tbl[f3];
      if (f3 == 0 && opb5 != 0 && f7b5 != 0) r.code = 1;
      if (f3 == 5 && f7b5 != 0) r.code = 7;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input int aluop, input int opb5, input int f3, input int f7b5,
                       input int f7b0);
    i_aluop    = 2'(aluop);
    i_opb5     = 1'(opb5);
    i_funct3   = 3'(f3);
    i_funct7b5 = 1'(f7b5);
    i_funct7b0 = 1'(f7b0);
  endtask

  // Full transaction; b2b keeps a request pending during the result cycle.
  task automatic run_op(input int aluop, input int opb5, input int f3, input int f7b5,
                        input int f7b0, input bit b2b);
    ref_t         r;
    logic [W-1:0] exp_code;
    r = ref_model(aluop, opb5, f3, f7b5, f7b0);
    chk("ready_before", o_ready, 1);
    drive(aluop, opb5, f3, f7b5, f7b0);
    i_valid = 1'b1;
    exp_q.push_back(W'(r.code));
    tick();
    i_valid = 1'b0;
    for (int c = 1; c < r.lat; c++) begin
      chk("busy", o_busy, 1);
      chk("valid_early", o_valid, 0);
      chk("ready_busy", o_ready, 0);
      tick();
    end
    exp_code = exp_q.pop_front();
    chk("valid", o_valid, 1);
    chk("busy_done", o_busy, 0);
    chk("ready_done", o_ready, 0);
    chk("code", o_alucrtl, exp_code);
    chk("illegal", o_illegal, r.ill);
    if (b2b) begin
      drive($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7), 0, 0);
      i_valid = 1'b1;
    end
    tick();
    i_valid = 1'b0;
    chk("idle_ready", o_ready, 1);
    chk("idle_valid", o_valid, 0);
    chk("hold_code", o_alucrtl, exp_code);
    chk("hold_illegal", o_illegal, r.ill);
  endtask

  initial begin
    int sel;
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_code", o_alucrtl, 0);
    chk("rst_illegal", o_illegal, 0);
    i_rst = 1'b0;
    tick();

    run_op(2, 1, 0, 1, 0, 0);   // sub
    run_op(2, 0, 5, 1, 0, 0);   // srai
    run_op(2, 0, 0, 1, 0, 0);   // addi
    run_op(2, 1, 4, 0, 1, 0);   // div: 32 busy cycles
    run_op(3, 0, 0, 0, 0, 0);   // illegal aluop
    run_op(2, 1, 3, 1, 1, 0);   // f7b0 and f7b5 together
    run_op(2, 1, 2, 1, 0, 0);   // R-type f7b5 with slt
    run_op(2, 1, 1, 0, 1, 0);   // mulh
    run_op(0, 0, 0, 0, 0, 1);   // request held during result cycle
    run_op(1, 0, 0, 0, 0, 1);

    // flush in the first multiply cycle
    drive(2, 1, 1, 0, 1);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("flush_mul_busy", o_busy, 1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush_mul_ready", o_ready, 1);
    chk("flush_mul_valid", o_valid, 0);
    chk("flush_mul_busy_after", o_busy, 0);
    chk("flush_mul_code", o_alucrtl, 17);
    for (int c = 0; c < 4; c++) begin
      chk("flush_mul_no_valid", o_valid, 0);
      tick();
    end

    // flush during the result cycle suppresses the strobe
    drive(2, 0, 1, 0, 0);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_flush = 1'b1;
    #1;
    chk("flush_done_valid", o_valid, 0);
    tick();
    i_flush = 1'b0;
    chk("flush_done_ready", o_ready, 1);
    chk("flush_done_code", o_alucrtl, 2);

    // flush blocks acceptance in IDLE
    drive(3, 0, 0, 0, 0);
    i_valid = 1'b1;
    i_flush = 1'b1;
    tick();
    i_valid = 1'b0;
    i_flush = 1'b0;
    chk("flush_block_valid", o_valid, 0);
    chk("flush_block_ready", o_ready, 1);
    chk("flush_block_illegal", o_illegal, 0);
    chk("flush_block_code", o_alucrtl, 2);

    // asynchronous reset mid-divide
    drive(2, 1, 6, 0, 1);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("div_busy_pre_rst", o_busy, 1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_ready", o_ready, 1);
    chk("arst_valid", o_valid, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_code", o_alucrtl, 0);
    chk("arst_illegal", o_illegal, 0);
    tick();
    i_rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      chk("arst_no_valid", o_valid, 0);
      tick();
    end

    // randomized requests
    for (int n = 0; n < 120; n++) begin
      sel = $urandom_range(0, 9);
      run_op((sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 3 : 2,
             $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
             ($urandom_range(0, 3) == 0) ? 1 : 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aludec_mc.md
ALUDEC_MC -- requirements
Module: aludec_mc

Interface
REQ-001 Parameter ALUCTRL_W, default 5, width of the ALU control code; the module SHALL reject values below 5 at elaboration.
REQ-002 Parameter MUL_CYCLES, default 2, busy cycles for multiply ops (>=1).
REQ-003 Parameter DIV_CYCLES, default 32, busy cycles for divide/remainder ops (>=1).
REQ-004 Ports, in order:
- i_clk, input, 1: single clock, rising edge.
- i_rst, input, 1: asynchronous, active-high reset.
- i_valid, input, 1: decode request.
- i_flush, input, 1: abort current operation.
- i_opb5, input, 1: opcode bit 5 (1 = R-type).
- i_funct3, input, 3: funct3.
- i_funct7b5, input, 1: funct7 bit 5.
- i_funct7b0, input, 1: funct7 bit 0 (M-extension).
- i_aluop, input, 2: main-decoder ALU op class.
- o_ready, output, 1: request can be accepted.
- o_valid, output, 1: one-cycle result strobe.
- o_alucrtl, output, ALUCTRL_W: ALU control code.
- o_illegal, output, 1: undecodable request.
- o_busy, output, 1: multi-cycle op in progress.

Function
REQ-005 Request accepted on a rising edge when i_valid=1, o_ready=1 and i_flush=0; o_ready SHALL equal 1 only in IDLE.
REQ-006 Codes (zero-extended to ALUCTRL_W): add 0, sub 1, sll 2, slt 3, sltu 4, xor 5, srl 6, sra 7, or 8, and 9, M ops 16+funct3 (mul 16 ... remu 23).
REQ-007 aluop 00 -> add; 01 -> sub; 10 -> decode by funct3 per REQ-008..010; 11 -> illegal.
REQ-008 funct3 000: sub if i_opb5 & i_funct7b5, else add; 001 sll; 010 slt; 011 sltu; 100 xor; 101 sra if i_funct7b5 else srl; 110 or; 111 and.
REQ-009 aluop 10 with i_opb5=1 and i_funct7b0=1 SHALL decode as M op 16+funct3; funct3[2]=0 is a multiply, funct3[2]=1 a divide/remainder.
REQ-010 Illegal: aluop 11; i_funct7b0 & i_funct7b5 both set with aluop 10 and i_opb5=1; R-type (i_opb5=1, aluop 10) with i_funct7b5=1 and funct3 not in {000,101}.
REQ-011 States: IDLE, MUL, DIV, DONE; single-cycle and illegal requests go IDLE->DONE; multiply IDLE->MUL; divide IDLE->DIV.
REQ-012 MUL/DIV SHALL hold a down-counter loaded with MUL_CYCLES-1 / DIV_CYCLES-1, decrement each cycle, and move to DONE when it reads 0.
REQ-013 DONE SHALL last exactly one cycle with o_valid=1, then return to IDLE; latency from accept to o_valid: 1 (single-cycle/illegal), MUL_CYCLES+1 (mul), DIV_CYCLES+1 (div).
REQ-014 o_alucrtl and o_illegal SHALL be registered at accept and held stable until the next accept; an illegal op SHALL give o_alucrtl=0, o_illegal=1.
REQ-015 o_busy SHALL be 1 exactly in MUL and DIV.
REQ-016 i_flush=1 in any state SHALL force IDLE at the next edge, suppress o_valid, and block acceptance that cycle; o_alucrtl/o_illegal keep their values.
REQ-017 A request presented while in DONE SHALL NOT be accepted (o_ready=0); back-to-back single-cycle requests therefore complete every 2 cycles.

Reset
REQ-018 While i_rst=1: state IDLE, counter 0, o_alucrtl 0, o_illegal 0, o_valid 0, o_busy 0, o_ready 1.
REQ-019 Reset asserted mid-MUL/DIV SHALL abort the operation immediately with no o_valid after release.

Structure
REQ-020 Shared package SHALL hold the state enum, the ALU code constants of REQ-006 and the aluop encodings.
REQ-021 One combinational sub-module, aludec_core (decode per REQ-007..010, outputs code, illegal, is_mul, is_div), is natural; FSM and counter live in aludec_mc.

Verification
REQ-022 aluop 10, opb5 1, funct3 000, f7b5 1 -> after 1 cycle o_valid=1, o_alucrtl=1, o_illegal=0.
REQ-023 aluop 10, opb5 0, funct3 101, f7b5 1 -> o_alucrtl=7; same with funct3 000 -> o_alucrtl=0 (addi).
REQ-024 aluop 10, opb5 1, f7b0 1, funct3 100, DIV_CYCLES 32 -> o_busy high 32 cycles, o_valid on cycle 33 with o_alucrtl=20, o_ready 0 throughout.
REQ-025 aluop 11 -> o_valid after 1 cycle, o_illegal=1, o_alucrtl=0.
REQ-026 mul accepted, i_flush pulsed in first MUL cycle -> IDLE next edge, no o_valid, o_ready=1.
REQ-027 i_rst asserted asynchronously mid-DIV -> all outputs at reset values without a clock edge; after release no o_valid.
